lsu: RTL and testbench
======================

# lsu

Load-store unit for the singlecycle core. It sits between the execute stage and `data_mem`. It turns a load/store request into a VALID/READY transaction on `data_mem`, builds the byte mask and lane-replicated write data, and sign/zero-extends load data. It stalls the core until the memory acknowledges, so the flop-based and SRAM-based memory variants are handled the same way.

## Interface
Parameters
- `ADDR_W`, 18: implemented byte-address width; must match `data_mem`.

Ports
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, synchronous and active-low.
- `i_lsu_en`  in  1  current instruction is a load or store.
- `i_lsu_wren`  in  1  1 = store, 0 = load.
- `i_lsu_funct3`  in  3  RV32I funct3 of the instruction.
- `i_lsu_addr`  in  32  byte address (rs1 + imm).
- `i_lsu_wdata`  in  32  rs2 store data.
- `o_lsu_rdata`  out  32  extended load result, registered.
- `o_lsu_stall`  out  1  freeze PC and pipeline.
- `o_lsu_fault`  out  1  misaligned, illegal funct3 or out-of-range address; one-cycle pulse.
- `o_ADDR`  out  18  memory byte address.
- `o_WDATA`  out  32  lane-replicated store data.
- `o_BMASK`  out  4  byte enables.
- `o_WREN`  out  1  memory write strobe qualifier.
- `i_RDATA`  in  32  raw memory word.
- `o_VALID`  out  1  request valid.
- `i_READY`  in  1  memory acknowledge.

## Operation
- FSM states: `IDLE`, `BUSY`, `DONE`.
- `IDLE` with `i_lsu_en`=1 and no fault:
  - register addr, funct3, wren, mask and wdata;
  - go to `BUSY`.
- `IDLE` with `i_lsu_en`=1 and a fault:
  - `o_lsu_fault`=1 for that cycle and `o_lsu_stall`=0;
  - no memory access; stay in `IDLE`.
- `BUSY`:
  - `o_VALID`=1; all `o_*` memory outputs come from registers and are held stable.
  - On `i_READY`=1, capture the extended `i_RDATA` into `o_lsu_rdata` (loads only) and go to `DONE`.
- `DONE`: `o_VALID`=0, then go to `IDLE`. This guarantees one VALID-low cycle between transactions.
- `o_lsu_stall` = `i_lsu_en` & (state ≠ `DONE`) & ~fault.
- Fault conditions:
  - LW/SW with addr[1:0]≠0;
  - LH/LHU/SH with addr[0]≠0;
  - load funct3 ∈ {011,110,111} or store funct3 > 010;
  - addr[31:ADDR_W]≠0.
- Byte mask:
  - SB: 4'b0001<<addr[1:0];
  - SH: 4'b0011<<{addr[1],1'b0};
  - SW: 4'b1111;
  - loads: 4'b1111.
- Write data:
  - SB: {4{wdata[7:0]}};
  - SH: {2{wdata[15:0]}};
  - SW: wdata unchanged.
- Load extraction:
  - shift `i_RDATA` right by 8·addr[1:0];
  - LB/LH sign-extend from bit 7/15;
  - LBU/LHU zero-extend;
  - LW unchanged.

## Timing
- Reset values: state `IDLE`; `o_VALID`, `o_WREN`, `o_lsu_stall`, `o_lsu_fault` = 0; `o_ADDR`, `o_WDATA`, `o_BMASK`, `o_lsu_rdata` = 0.
- Latency, with the request sampled in cycle t:
  - `BUSY` at t+1;
  - with an always-ready memory, `i_READY`=1 at t+1 and `DONE` at t+2, where stall is low and rdata is valid;
  - with SRAM memory, `DONE` is one cycle after the `i_READY` cycle, whatever the wait.
- Handshake:
  - VALID never drops before READY;
  - request fields do not change while VALID=1;
  - READY seen while not in `BUSY` is ignored.
- `o_lsu_rdata` holds its value until the next completed load. Stores do not change it.
- Reset asserted mid-`BUSY`: next cycle `IDLE` with `o_VALID`=0. A store already accepted by memory may have completed.
- `i_lsu_en` dropping while in `BUSY` (pipeline flush): the transaction still finishes; the result is discarded by the core.

## Structure
- `singlecycle_pkg` gains:
  - `lsu_state_e`;
  - funct3 constants `F3_B`=3'b000, `F3_H`=3'b001, `F3_W`=3'b010, `F3_BU`=3'b100, `F3_HU`=3'b101.
- One combinational sub-module, `lsu_align`: mask generation, write-data replication, load extract/extend and fault decode. The FSM and registers stay in `lsu`.

## Test plan
- SW 0x000_0010 data 0xDEADBEEF, then LW same address, on the flop memory: BMASK=1111 on the store; rdata=0xDEADBEEF at t+2; stall high for exactly 2 cycles.
- SB 0x13 data 0x000000A5, then LB 0x13 and LBU 0x13: BMASK=1000 and WDATA=0xA5A5A5A5 on the store; LB=0xFFFFFFA5; LBU=0x000000A5.
- SH 0x22 data 0x8001, then LH 0x22 and LHU 0x22: BMASK=1100; LH=0xFFFF8001; LHU=0x00008001.
- LW 0x05, SH 0x03 and LB 0x0004_0000: `o_lsu_fault` pulses, stall=0, `o_VALID` never rises.
- SRAM memory with READY delayed 4 cycles: VALID and fields stay stable; stall releases the cycle after READY; the read word is correct.
- Reset asserted in `BUSY`: `o_VALID`=0 and state `IDLE` the next cycle; a following LW completes normally.

Source files
------------

// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the singlecycle core.
package singlecycle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath for the LSU: request fault decode, byte mask and
// store-lane replication, plus load-lane extraction and sign/zero extension.
module lsu_align
  import singlecycle_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic        req_wren,
  input  logic [31:0] req_wdata,
  output logic [3:0]  req_bmask,
  output logic [31:0] req_wdata_rep,
  output logic        req_fault,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [2:0]  rsp_funct3,
  input  logic [31:0] rsp_raw,
  output logic [31:0] rsp_rdata
);

  logic        misaligned;
  logic        illegal;
  logic        out_of_range;
  logic [31:0] shifted;

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3)
      F3_W:        misaligned = (req_addr[1:0] != 2'b00);
      F3_H, F3_HU: misaligned = req_addr[0];
      default:     misaligned = 1'b0;
    endcase
  end

  // Stores only have B/H/W encodings; loads reject the three unused slots.
  assign illegal = req_wren ? (req_funct3 > F3_W)
                            : (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                               req_funct3 == 3'b111);
  assign out_of_range = |req_addr[31:ADDR_W];
  assign req_fault    = misaligned | illegal | out_of_range;

  always_comb begin
    req_bmask     = 4'b1111;
    req_wdata_rep = req_wdata;
    if (req_wren) begin
      case (req_funct3)
        F3_B: begin
          req_bmask     = 4'b0001 << req_addr[1:0];
          req_wdata_rep = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          req_bmask     = 4'b0011 << {req_addr[1], 1'b0};
          req_wdata_rep = {2{req_wdata[15:0]}};
        end
        default: begin
          req_bmask     = 4'b1111;
          req_wdata_rep = req_wdata;
        end
      endcase
    end
  end

  assign shifted = rsp_raw >> {rsp_addr_lo, 3'b000};

  always_comb begin
    rsp_rdata = shifted;
    case (rsp_funct3)
      F3_B:    rsp_rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rsp_rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rsp_rdata = {24'd0, shifted[7:0]};
      F3_HU:   rsp_rdata = {16'd0, shifted[15:0]};
      default: rsp_rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load-store unit: one VALID/READY memory transaction per load/store, core
// stalled from request until the cycle after READY; faults complete with no access.
module lsu
  import singlecycle_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_en,
  input  logic              i_lsu_wren,
  input  logic [2:0]        i_lsu_funct3,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_lsu_wdata,
  output logic [31:0]       o_lsu_rdata,
  output logic              o_lsu_stall,
  output logic              o_lsu_fault,
  output logic [ADDR_W-1:0] o_ADDR,
  output logic [31:0]       o_WDATA,
  output logic [3:0]        o_BMASK,
  output logic              o_WREN,
  input  logic [31:0]       i_RDATA,
  output logic              o_VALID,
  input  logic              i_READY
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q;
  logic [3:0]  req_bmask;
  logic [31:0] req_wdata_rep;
  logic [31:0] ld_data;
  logic        req_fault;
  logic        idle;
  logic        accept;

  lsu_align #(.ADDR_W(ADDR_W)) u_align (
    .req_addr      (i_lsu_addr),
    .req_funct3    (i_lsu_funct3),
    .req_wren      (i_lsu_wren),
    .req_wdata     (i_lsu_wdata),
    .req_bmask     (req_bmask),
    .req_wdata_rep (req_wdata_rep),
    .req_fault     (req_fault),
    .rsp_addr_lo   (o_ADDR[1:0]),
    .rsp_funct3    (funct3_q),
    .rsp_raw       (i_RDATA),
    .rsp_rdata     (ld_data)
  );

  assign idle        = (state_q == IDLE);
  assign o_lsu_fault = i_lsu_en & idle & req_fault;
  assign accept      = i_lsu_en & idle & ~req_fault;
  // DONE releases the core; the frozen instruction retires on that edge.
  assign o_lsu_stall = i_lsu_en & (state_q != DONE) & ~o_lsu_fault;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_VALID = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        o_VALID = 1'b1;
        if (i_READY) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ADDR      <= '0;
      o_WDATA     <= '0;
      o_BMASK     <= '0;
      o_WREN      <= 1'b0;
      funct3_q    <= '0;
      o_lsu_rdata <= '0;
    end else begin
      if (accept) begin
        o_ADDR   <= i_lsu_addr[ADDR_W-1:0];
        o_WDATA  <= req_wdata_rep;
        o_BMASK  <= req_bmask;
        o_WREN   <= i_lsu_wren;
        funct3_q <= i_lsu_funct3;
      end
      if (state_q == BUSY && i_READY && !o_WREN) o_lsu_rdata <= ld_data;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed test-plan scenarios plus randomized loads/stores
// checked against a byte-addressed reference memory model.
module tb_lsu;
  import singlecycle_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        lsu_en, lsu_wren;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_stall, o_lsu_fault;
  logic [17:0] o_ADDR;
  logic [31:0] o_WDATA;
  logic [3:0]  o_BMASK;
  logic        o_WREN, o_VALID;
  logic [31:0] i_RDATA;
  logic        i_READY;

  int vectors = 0;
  int miscompares = 0;

  lsu #(.ADDR_W(18)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_lsu_en(lsu_en), .i_lsu_wren(lsu_wren), .i_lsu_funct3(lsu_funct3),
    .i_lsu_addr(lsu_addr), .i_lsu_wdata(lsu_wdata),
    .o_lsu_rdata(o_lsu_rdata), .o_lsu_stall(o_lsu_stall), .o_lsu_fault(o_lsu_fault),
    .o_ADDR(o_ADDR), .o_WDATA(o_WDATA), .o_BMASK(o_BMASK), .o_WREN(o_WREN),
    .i_RDATA(i_RDATA), .o_VALID(o_VALID), .i_READY(i_READY)
  );

  always #5 i_clk = ~i_clk;

  // Memory seen by the DUT: word array, READY after mem_delay VALID cycles.
  logic [31:0] mem [0:255];
  logic        mem_seeded = 1'b0;
  int          mem_delay = 0;
  int          wait_cnt = 0;

  function automatic logic [31:0] seed_word(input int w);
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign i_READY = (mem_delay == 0) ? 1'b1 : (o_VALID && wait_cnt == mem_delay);
  assign i_RDATA = i_READY ? mem[o_ADDR[9:2]] : 32'hBAD0_BAD0;

  always @(posedge i_clk) begin
    if (!mem_seeded) begin
      for (int w = 0; w < 256; w++) mem[w] <= seed_word(w);
      mem_seeded <= 1'b1;
    end else if (o_VALID && i_READY && o_WREN) begin
      for (int b = 0; b < 4; b++)
        if (o_BMASK[b]) mem[o_ADDR[9:2]][8*b +: 8] <= o_WDATA[8*b +: 8];
    end
    if (!o_VALID)      wait_cnt <= 0;
    else if (!i_READY) wait_cnt <= wait_cnt + 1;
  end

  // Reference model: flat byte memory and access rules in plain arithmetic.
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] last_rd;

  function automatic int ref_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic ref_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (wr && f3 > 3'd2) return 1'b1;
    if (!wr && (f3 == 3'd3 || f3 > 3'd5)) return 1'b1;
    if (a >= 32'h0004_0000) return 1'b1;
    if (a % ref_size(f3) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = 0;
    int n = ref_size(f3);
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (f3 == 3'd0 && v >= 128)   v = v - 256;
    if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [3:0] ref_mask(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m = 4'b0000;
    int off = int'(a % 4);
    if (!wr) return 4'b1111;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + ref_size(f3)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r = 0;
    int n = ref_size(f3);
    for (int i = 0; i < 4; i++) r = r + (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < ref_size(f3); i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // Drives one request and holds it until the core is released.
  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int stalls, output logic flt, output logic vseen, output logic stable,
                        output logic [31:0] rd, output logic [17:0] ao, output logic [31:0] wdo,
                        output logic [3:0] bm, output logic wo);
    logic done;
    lsu_en = 1'b1; lsu_wren = wr; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    stalls = 0; flt = 0; vseen = 0; stable = 1; rd = '0; ao = '0; wdo = '0; bm = '0; wo = 0; done = 0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge i_clk);
      if (o_lsu_fault) flt = 1'b1;
      if (o_VALID) begin
        if (!vseen) begin
          vseen = 1'b1; ao = o_ADDR; wdo = o_WDATA; bm = o_BMASK; wo = o_WREN;
        end else if (o_ADDR !== ao || o_WDATA !== wdo || o_BMASK !== bm || o_WREN !== wo) begin
          stable = 1'b0;
        end
      end
      if (o_lsu_stall) stalls++;
      else begin
        done = 1'b1;
        rd = o_lsu_rdata;
      end
      @(posedge i_clk); #1;
    end
    if (!done) stalls = 99;
    lsu_en = 1'b0;
  endtask

  int stalls; logic flt, vseen, stable, wo;
  logic [31:0] rd, wdo; logic [17:0] ao; logic [3:0] bm;

  task automatic test_reset();
    i_rst_n = 1'b0; lsu_en = 1'b0; lsu_wren = 1'b0; lsu_funct3 = 3'd0; lsu_addr = '0; lsu_wdata = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    vectors++;
    if ({o_VALID, o_WREN, o_lsu_stall, o_lsu_fault} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ctl got=%b exp=0000", {o_VALID, o_WREN, o_lsu_stall, o_lsu_fault});
    end
    vectors++;
    if (o_ADDR !== 18'd0 || o_WDATA !== 32'd0 || o_BMASK !== 4'd0) begin
      miscompares++; $display("FAIL reset_fields got addr=%h wdata=%h bmask=%b exp=0", o_ADDR, o_WDATA, o_BMASK);
    end
    vectors++;
    if (o_lsu_rdata !== 32'd0) begin
      miscompares++; $display("FAIL reset_rdata got=%h exp=0", o_lsu_rdata);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    last_rd = '0;
  endtask

  task automatic test_word();
    run_op(1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    ref_store(F3_W, 32'h10, 32'hDEAD_BEEF);
    vectors++;
    if (bm !== 4'b1111 || stalls != 2) begin
      miscompares++; $display("FAIL sw_word got bmask=%b stalls=%0d exp bmask=1111 stalls=2", bm, stalls);
    end
    run_op(1'b0, F3_W, 32'h10, 32'h0, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || stalls != 2) begin
      miscompares++; $display("FAIL lw_word got rdata=%h stalls=%0d exp rdata=deadbeef stalls=2", rd, stalls);
    end
    last_rd = 32'hDEAD_BEEF;
  endtask

  task automatic test_byte();
    run_op(1'b1, F3_B, 32'h13, 32'h0000_00A5, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    ref_store(F3_B, 32'h13, 32'h0000_00A5);
    vectors++;
    if (bm !== 4'b1000 || wdo !== 32'hA5A5_A5A5) begin
      miscompares++; $display("FAIL sb got bmask=%b wdata=%h exp bmask=1000 wdata=a5a5a5a5", bm, wdo);
    end
    run_op(1'b0, F3_B, 32'h13, 32'h0, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    vectors++;
    if (rd !== 32'hFFFF_FFA5) begin
      miscompares++; $display("FAIL lb got=%h exp=ffffffa5", rd);
    end
    run_op(1'b0, F3_BU, 32'h13, 32'h0, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    vectors++;
    if (rd !== 32'h0000_00A5) begin
      miscompares++; $display("FAIL lbu got=%h exp=000000a5", rd);
    end
    last_rd = 32'h0000_00A5;
  endtask

  task automatic test_half();
    run_op(1'b1, F3_H, 32'h22, 32'h0000_8001, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    ref_store(F3_H, 32'h22, 32'h0000_8001);
    vectors++;
    if (bm !== 4'b1100 || wdo !== 32'h8001_8001) begin
      miscompares++; $display("FAIL sh got bmask=%b wdata=%h exp bmask=1100 wdata=80018001", bm, wdo);
    end
    run_op(1'b0, F3_H, 32'h22, 32'h0, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    vectors++;
    if (rd !== 32'hFFFF_8001) begin
      miscompares++; $display("FAIL lh got=%h exp=ffff8001", rd);
    end
    run_op(1'b0, F3_HU, 32'h22, 32'h0, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    vectors++;
    if (rd !== 32'h0000_8001) begin
      miscompares++; $display("FAIL lhu got=%h exp=00008001", rd);
    end
    last_rd = 32'h0000_8001;
  endtask

  task automatic test_faults();
    logic        f_wr [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f_f3 [5] = '{F3_W, F3_H, F3_B, 3'b011, 3'b100};
    logic [31:0] f_a  [5] = '{32'h5, 32'h3, 32'h0004_0000, 32'h8, 32'h8};
    for (int i = 0; i < 5; i++) begin
      run_op(f_wr[i], f_f3[i], f_a[i], 32'h1234_5678, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
      vectors++;
      if (flt !== 1'b1 || stalls != 0 || vseen !== 1'b0 || rd !== last_rd) begin
        miscompares++;
        $display("FAIL fault_%0d got fault=%b stalls=%0d valid=%b rdata=%h exp fault=1 stalls=0 valid=0 rdata=%h",
                 i, flt, stalls, vseen, rd, last_rd);
      end
    end
  endtask

  task automatic test_sram_wait();
    logic [31:0] wd = $urandom;
    mem_delay = 4;
    run_op(1'b1, F3_W, 32'h40, wd, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    ref_store(F3_W, 32'h40, wd);
    vectors++;
    if (stalls != 6 || stable !== 1'b1 || ao !== 18'h40 || wdo !== wd) begin
      miscompares++; $display("FAIL sram_sw got stalls=%0d stable=%b addr=%h wdata=%h exp 6 1 40 %h", stalls, stable, ao, wdo, wd);
    end
    run_op(1'b0, F3_W, 32'h40, 32'h0, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    vectors++;
    if (stalls != 6 || stable !== 1'b1 || rd !== wd) begin
      miscompares++; $display("FAIL sram_lw got stalls=%0d stable=%b rdata=%h exp 6 1 %h", stalls, stable, rd, wd);
    end
    last_rd = wd;
    mem_delay = 0;
  endtask

  task automatic test_reset_busy();
    logic [31:0] exp;
    mem_delay = 6;
    lsu_en = 1'b1; lsu_wren = 1'b0; lsu_funct3 = F3_W; lsu_addr = 32'h10; lsu_wdata = '0;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    vectors++;
    if (o_VALID !== 1'b1) begin
      miscompares++; $display("FAIL rst_busy_pre got valid=%b exp 1", o_VALID);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b0; lsu_en = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    vectors++;
    if (o_VALID !== 1'b0 || o_lsu_rdata !== 32'd0) begin
      miscompares++; $display("FAIL rst_busy got valid=%b rdata=%h exp valid=0 rdata=0", o_VALID, o_lsu_rdata);
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1; mem_delay = 0; last_rd = '0;
    exp = ref_load(F3_W, 32'h10);
    run_op(1'b0, F3_W, 32'h10, 32'h0, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
    vectors++;
    if (rd !== exp || stalls != 2) begin
      miscompares++; $display("FAIL rst_busy_lw got rdata=%h stalls=%0d exp rdata=%h stalls=2", rd, stalls, exp);
    end
    last_rd = exp;
  endtask

  task automatic test_random();
    logic wr; logic [2:0] f3; logic [31:0] a, wd, exp_rd; logic ef; int sz;
    for (int k = 0; k < 150; k++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      sz = ref_size(f3);
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a = a - (a % sz);
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(18, 31));
      wd = $urandom;
      mem_delay = $urandom_range(0, 3);
      ef = ref_fault(wr, f3, a);
      exp_rd = (!ef && !wr) ? ref_load(f3, a) : last_rd;
      run_op(wr, f3, a, wd, stalls, flt, vseen, stable, rd, ao, wdo, bm, wo);
      vectors++;
      if (flt !== ef || vseen !== !ef || stalls != (ef ? 0 : 2 + mem_delay)) begin
        miscompares++;
        $display("FAIL rnd_ctl[%0d] wr=%b f3=%0d a=%h got fault=%b valid=%b stalls=%0d exp fault=%b stalls=%0d",
                 k, wr, f3, a, flt, vseen, stalls, ef, ef ? 0 : 2 + mem_delay);
      end
      vectors++;
      if (rd !== exp_rd) begin
        miscompares++; $display("FAIL rnd_rdata[%0d] wr=%b f3=%0d a=%h got=%h exp=%h", k, wr, f3, a, rd, exp_rd);
      end
      if (!ef) begin
        vectors++;
        if (stable !== 1'b1 || ao !== a[17:0] || wo !== wr || bm !== ref_mask(wr, f3, a)) begin
          miscompares++;
          $display("FAIL rnd_req[%0d] got stable=%b addr=%h wren=%b bmask=%b exp 1 %h %b %b",
                   k, stable, ao, wo, bm, a[17:0], wr, ref_mask(wr, f3, a));
        end
        if (wr) begin
          vectors++;
          if (wdo !== ref_wdata(f3, wd)) begin
            miscompares++; $display("FAIL rnd_wdata[%0d] f3=%0d got=%h exp=%h", k, f3, wdo, ref_wdata(f3, wd));
          end
          ref_store(f3, a, wd);
        end
      end
      last_rd = exp_rd;
    end
    mem_delay = 0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ref_mem[a] = seed_word(a / 4)[8 * (a % 4) +: 8];
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_sram_wait();
    test_reset_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
